// File: rtl/uart_tx_burst_ctrl.sv
// rtl/uart_tx_burst_ctrl.sv - burst sequencer feeding memory bytes to UART_TX over tx_start/tx_done
module uart_tx_burst_ctrl #(
    parameter int ADDR_WIDTH = 16,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  go,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  byte_count,
    input  logic                  abort,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [7:0]            mem_rd_data,
    output logic                  tx_start,
    output logic [7:0]            tx_byte,
    input  logic                  tx_done,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic [LEN_WIDTH-1:0]  bytes_sent
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = LEN_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_ISSUE,
        S_GUARD,
        S_WAIT_DONE
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  remaining;
    logic [LEN_WIDTH-1:0]  remaining_dec;
    logic                  abort_latch;
    logic                  abort_seen;
    logic                  start_burst;
    logic                  zero_burst;
    logic                  frame_done;
    logic                  burst_end;

    // Saturating decrement keeps remaining from wrapping below zero.
    assign remaining_dec = (remaining != '0) ? (remaining - LEN_ONE) : '0;
    // An abort arriving on the very cycle the last frame finishes still counts.
    assign abort_seen    = abort_latch | abort;

    assign mem_rd_en = (state == S_FETCH);
    assign mem_addr  = (state == S_FETCH) ? addr : '0;

    always_comb begin
        state_next  = state;
        start_burst = 1'b0;
        zero_burst  = 1'b0;
        frame_done  = 1'b0;
        burst_end   = 1'b0;
        case (state)
            S_IDLE: begin
                if (go) begin
                    if (byte_count != '0) begin
                        start_burst = 1'b1;
                        state_next  = S_FETCH;
                    end else begin
                        zero_burst  = 1'b1;
                    end
                end
            end
            S_FETCH:   state_next = S_CAPTURE;
            S_CAPTURE: state_next = S_ISSUE;
            S_ISSUE:   state_next = S_GUARD;
            // tx_done may still be high from the previous frame here.
            S_GUARD:   state_next = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (tx_done) begin
                    frame_done = 1'b1;
                    if ((remaining_dec == '0) || abort_seen) begin
                        burst_end  = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        state_next = S_FETCH;
                    end
                end
            end
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            addr        <= '0;
            remaining   <= '0;
            abort_latch <= 1'b0;
            tx_start    <= 1'b0;
            tx_byte     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
            bytes_sent  <= '0;
        end else begin
            state    <= state_next;
            busy     <= (state_next != S_IDLE);
            tx_start <= (state_next == S_ISSUE);
            done     <= 1'b0;

            if (start_burst) begin
                addr        <= base_addr;
                remaining   <= byte_count;
                bytes_sent  <= '0;
                aborted     <= 1'b0;
                abort_latch <= 1'b0;
            end

            if (zero_burst) begin
                bytes_sent <= '0;
                aborted    <= 1'b0;
                done       <= 1'b1;
            end

            if ((state != S_IDLE) && abort) begin
                abort_latch <= 1'b1;
            end

            if (state == S_CAPTURE) begin
                tx_byte <= mem_rd_data;
            end

            if (frame_done) begin
                bytes_sent <= bytes_sent + LEN_ONE;
                remaining  <= remaining_dec;
                addr       <= addr + ADDR_ONE;
            end

            if (burst_end) begin
                done    <= 1'b1;
                aborted <= abort_seen && (remaining_dec != '0);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_burst_ctrl.sv
// tb/tb_uart_tx_burst_ctrl.sv - directed self-checking bench for uart_tx_burst_ctrl
module tb_uart_tx_burst_ctrl;

    localparam int AW  = 8;
    localparam int LW  = 16;
    localparam int C   = 50;
    localparam int D   = 2;
    localparam int K   = 10 * C + D;
    localparam int PER = K + 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          go;
    logic [AW-1:0] base_addr;
    logic [LW-1:0] byte_count;
    logic          abort;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [7:0]    rd_data;
    logic          tx_start;
    logic [7:0]    tx_byte;
    logic          tx_done = 1'b1;
    logic          busy;
    logic          done;
    logic          aborted;
    logic [LW-1:0] bytes_sent;

    uart_tx_burst_ctrl #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst_n(rst_n), .go(go), .base_addr(base_addr),
        .byte_count(byte_count), .abort(abort), .mem_rd_en(mem_rd_en),
        .mem_addr(mem_addr), .mem_rd_data(rd_data), .tx_start(tx_start),
        .tx_byte(tx_byte), .tx_done(tx_done), .busy(busy), .done(done),
        .aborted(aborted), .bytes_sent(bytes_sent)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    always @(posedge clk) if (mem_rd_en) rd_data <= mem[mem_addr];

    // UART_TX stand-in: tx_done drops after start and rises K cycles later.
    int ucnt = 0;
    always @(posedge clk) begin
        if (tx_start) begin
            tx_done <= 1'b0;
            ucnt    <= K;
        end else if (ucnt > 0) begin
            ucnt <= ucnt - 1;
            if (ucnt == 1) tx_done <= 1'b1;
        end
    end

    int         cyc = 0;
    int         n_start = 0;
    int         n_rd = 0;
    int         start_cyc [64];
    logic [7:0] start_byte [64];
    logic [7:0] rd_addr [64];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tx_start && n_start < 64) begin
            start_cyc[n_start]  <= cyc + 1;
            start_byte[n_start] <= tx_byte;
            n_start             <= n_start + 1;
        end
        if (mem_rd_en && n_rd < 64) begin
            rd_addr[n_rd] <= mem_addr;
            n_rd          <= n_rd + 1;
        end
    end

    int checks = 0;
    int errors = 0;
    int t0, s0, r0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [AW-1:0] b, input logic [LW-1:0] n);
        s0         = n_start;
        r0         = n_rd;
        go         = 1'b1;
        base_addr  = b;
        byte_count = n;
        tick();
        go = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_done_seen"}, done, 1);
    endtask

    task automatic wait_starts(input string tag, input int cnt, input int budget);
        int n = 0;
        while ((n_start - s0) < cnt && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_starts_seen"}, n_start - s0, cnt);
    endtask

    initial begin
        rst_n = 1'b0; go = 1'b0; abort = 1'b0; base_addr = '0; byte_count = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[8'h10] = 8'hA5;
        mem[8'hFE] = 8'h11; mem[8'hFF] = 8'h22; mem[8'h00] = 8'h33; mem[8'h01] = 8'h44;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_mem_rd_en", mem_rd_en, 0);
        chk("rst_bytes_sent", bytes_sent, 0);
        chk("rst_aborted", aborted, 0);

        // single byte
        start(8'h10, 1);
        chk("t1_busy_after_go", busy, 1);
        chk("t1_rd_en_first_cycle", mem_rd_en, 1);
        wait_done("t1", 2000);
        chk("t1_latency", cyc - t0, PER);
        chk("t1_busy_at_done", busy, 0);
        chk("t1_bytes_sent", bytes_sent, 1);
        chk("t1_aborted", aborted, 0);
        chk("t1_n_start", n_start - s0, 1);
        chk("t1_byte", start_byte[s0], 8'hA5);
        chk("t1_start_lat", start_cyc[s0] - t0, 3);
        chk("t1_rd_addr", rd_addr[r0], 8'h10);
        tick();
        chk("t1_done_pulse", done, 0);

        // burst with address wrap
        start(8'hFE, 4);
        wait_done("t2", 4 * PER + 50);
        chk("t2_latency", cyc - t0, 4 * PER);
        chk("t2_n_start", n_start - s0, 4);
        chk("t2_bytes_sent", bytes_sent, 4);
        chk("t2_rd0", rd_addr[r0],     8'hFE);
        chk("t2_rd1", rd_addr[r0 + 1], 8'hFF);
        chk("t2_rd2", rd_addr[r0 + 2], 8'h00);
        chk("t2_rd3", rd_addr[r0 + 3], 8'h01);
        chk("t2_byte0", start_byte[s0],     8'h11);
        chk("t2_byte1", start_byte[s0 + 1], 8'h22);
        chk("t2_byte2", start_byte[s0 + 2], 8'h33);
        chk("t2_byte3", start_byte[s0 + 3], 8'h44);
        for (int i = 1; i < 4; i++)
            chk("t2_spacing", start_cyc[s0 + i] - start_cyc[s0 + i - 1], PER);
        tick();

        // zero count
        start(8'h20, 0);
        chk("t3_done", done, 1);
        chk("t3_busy", busy, 0);
        chk("t3_bytes_sent", bytes_sent, 0);
        chk("t3_aborted", aborted, 0);
        tick();
        chk("t3_done_pulse", done, 0);
        chk("t3_busy_after", busy, 0);
        chk("t3_no_start", n_start - s0, 0);
        chk("t3_no_read", n_rd - r0, 0);

        // abort during second frame
        start(8'h20, 5);
        wait_starts("t4", 2, 2 * PER + 50);
        repeat (10) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_done("t4", PER + 50);
        chk("t4_aborted", aborted, 1);
        chk("t4_bytes_sent", bytes_sent, 2);
        chk("t4_tx_done", tx_done, 1);
        chk("t4_byte1", start_byte[s0 + 1], 8'h21 ^ 8'h5A);
        repeat (2 * PER) tick();
        chk("t4_no_third", n_start - s0, 2);
        chk("t4_aborted_held", aborted, 1);

        // abort during the last frame does not flag aborted
        start(8'h30, 1);
        chk("t4b_aborted_cleared", aborted, 0);
        wait_starts("t4b", 1, 50);
        repeat (5) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_done("t4b", PER + 50);
        chk("t4b_aborted", aborted, 0);
        chk("t4b_bytes_sent", bytes_sent, 1);
        tick();

        // go hammered while busy
        start(8'h40, 3);
        for (int n = 0; n < 3 * PER + 50 && done !== 1'b1; n++) begin
            go         = 1'b1;
            base_addr  = 8'($urandom);
            byte_count = 16'd7;
            tick();
        end
        go = 1'b0;
        chk("t5_done_seen", done, 1);
        chk("t5_latency", cyc - t0, 3 * PER);
        chk("t5_bytes_sent", bytes_sent, 3);
        chk("t5_n_start", n_start - s0, 3);
        chk("t5_byte0", start_byte[s0],     8'h40 ^ 8'h5A);
        chk("t5_byte2", start_byte[s0 + 2], 8'h42 ^ 8'h5A);
        tick();
        chk("t5_idle_after", busy, 0);

        // reset during FETCH of the second byte
        start(8'h50, 3);
        for (int n = 0; n < 2 * PER && !((n_rd - r0) == 1 && mem_rd_en === 1'b1); n++) tick();
        chk("t6_in_fetch2", mem_rd_en, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_tx_start", tx_start, 0);
        chk("t6_bytes_sent", bytes_sent, 0);
        chk("t6_rd_en", mem_rd_en, 0);
        for (int n = 0; n < 2 * PER && tx_done !== 1'b1; n++) tick();
        chk("t6_uart_idle", tx_done, 1);
        start(8'h60, 2);
        wait_done("t6", 2 * PER + 50);
        chk("t6_latency", cyc - t0, 2 * PER);
        chk("t6_bytes_sent_new", bytes_sent, 2);
        chk("t6_byte0", start_byte[s0],     8'h60 ^ 8'h5A);
        chk("t6_byte1", start_byte[s0 + 1], 8'h61 ^ 8'h5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_burst_ctrl.md
# uart_tx_burst_ctrl

Burst sequencer for the UART transmitter. On a `go` pulse it reads `byte_count` bytes from data memory, starting at `base_addr`. It hands each byte to `UART_TX` over the transmitter's `tx_start`/`tx_done` handshake, tracks progress, and reports completion. It sits between the processor's IO/control logic and `UART_TX`, so the processor can dump a memory region over serial with one command.

## Interface
- `ADDR_WIDTH`, 16: data-memory address width.
- `LEN_WIDTH`, 16: width of the byte count and progress counter.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `go` in 1: start command, sampled only in IDLE.
- `base_addr` in ADDR_WIDTH: first byte address, captured on accepted `go`.
- `byte_count` in LEN_WIDTH: number of bytes, captured on accepted `go`.
- `abort` in 1: stop the burst after the frame in flight.
- `mem_rd_en` out 1: memory read strobe.
- `mem_addr` out ADDR_WIDTH: read address.
- `mem_rd_data` in 8: read data, valid the cycle after `mem_rd_en`.
- `tx_start` out 1: to `UART_TX` `tx_start`, one-cycle pulse.
- `tx_byte` out 8: to `UART_TX` `in_data_byte`, held stable while `tx_start`=1.
- `tx_done` in 1: from `UART_TX`; a level that clears the cycle after start is accepted and sets when the frame ends.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when a burst ends.
- `aborted` out 1: qualifies `done`; 1 means the burst ended by abort.
- `bytes_sent` out LEN_WIDTH: bytes completed in the current or last burst.

## Operation
States: IDLE, FETCH, CAPTURE, ISSUE, GUARD, WAIT_DONE.

Transitions:
- **IDLE**: `busy`=0.
  - On `go`=1 with `byte_count`≠0: latch `addr`←`base_addr` and `remaining`←`byte_count`; clear `bytes_sent`, `aborted` and the abort latch; go to FETCH.
  - On `go`=1 with `byte_count`=0: clear `bytes_sent`, pulse `done` next cycle with `aborted`=0, stay in IDLE.
- **FETCH**: `mem_rd_en`=1, `mem_addr`=`addr`; go to CAPTURE.
- **CAPTURE**: register `mem_rd_data` into `tx_byte`; go to ISSUE.
- **ISSUE**: `tx_start`=1 for exactly this cycle; go to GUARD.
- **GUARD**: one cycle that ignores `tx_done` (stale high from the previous frame); go to WAIT_DONE.
- **WAIT_DONE**: stay while `tx_done`=0. On `tx_done`=1, apply the completion updates below, then:
  - go to IDLE with a `done` pulse if `remaining` reaches 0 or the abort latch is set;
  - otherwise go to FETCH.

Completion updates on WAIT_DONE exit:
- `bytes_sent`+1
- `remaining`−1
- `addr`+1

Arithmetic and flags:
- `addr` wraps modulo 2^ADDR_WIDTH with no error.
- `remaining` never underflows.
- `abort` in any non-IDLE state sets a sticky latch. A frame already issued always completes (the UART is never cut mid-frame). If abort arrives in FETCH or CAPTURE, that byte is still issued.
- `abort` in IDLE is ignored.
- `aborted` is set with the `done` pulse, is 1 only if the latch was set and `remaining`≠0 at exit, and holds until the next accepted `go`.
- `go` outside IDLE is ignored.

Reset (`rst_n`=0 at an edge), including mid-burst:
- State → IDLE.
- All outputs, `addr`, `remaining` and the latch → 0.
- A frame already in the UART is not cancelled; the next `go` after reset must not be issued until `tx_done`=1. A bench can cover this with a `go` pending until `tx_done`, or by resetting the UART together with this block.

## Timing
- Accepted `go` at edge E → `mem_rd_en` in the cycle after E → `tx_start` 3 cycles after E.
- With `UART_TX` (CLOCKS_PER_BIT=C, DELAY=D), `tx_done` rises C·10+D cycles after the edge that samples `tx_start`.
- Per-byte period, start pulse to start pulse: 10·C+D+4 cycles.
- `done` asserts the cycle after the final WAIT_DONE exit.
- `busy` falls in the same cycle `done` asserts.
- Burst of N bytes, measured from `go` accept to the `done` cycle: N·(10·C+D+4) cycles.
- Outputs are registered, except `mem_addr`/`mem_rd_en`, which are decoded from state and `addr` (no glitches, held the full FETCH cycle).

## Test plan
- **Single byte:** memory[0x10]=0xA5, `go` with base 0x10 and count 1, using `UART_TX` at C=50, D=2 → serial line shows start bit, bits 1,0,1,0,0,1,0,1 (LSB first), stop bit; `done` pulse at cycle 506 after accept; `bytes_sent`=1; `aborted`=0.
- **Burst with wrap:** ADDR_WIDTH=4, base 0xE, count 4 → reads 0xE, 0xF, 0x0, 0x1 in order; exactly 4 `tx_start` pulses, each 506 cycles apart; `bytes_sent`=4.
- **Zero count:** `go` with count 0 → no `mem_rd_en`, no `tx_start`, `done` the next cycle, `busy` never 1.
- **Abort mid-burst:** count 5, `abort` during the 2nd frame's WAIT_DONE → the 2nd frame completes cleanly, no 3rd `tx_start`, `done`=1 with `aborted`=1, `bytes_sent`=2.
- **Ignored go:** `go` repeated every cycle while `busy` → the burst is unchanged, and exactly count bytes are sent.
- **Reset mid-burst:** `rst_n`=0 for 1 cycle during FETCH of byte 2 → next cycle `busy`=0, `done`=0, `tx_start`=0, `bytes_sent`=0; a new `go` after `tx_done`=1 runs a correct burst.
